// File: rtl/mem_copy_dma_if.sv
// Memory-side bus between the copy engine (master) and a single-cycle 16-bit memory (slave).
interface mem_copy_dma_if;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_createdump;

   modport master (
      output mem_enable,
      output mem_wr,
      output mem_addr,
      output mem_wdata,
      output mem_createdump,
      input  mem_rdata
   );

   modport slave (
      input  mem_enable,
      input  mem_wr,
      input  mem_addr,
      input  mem_wdata,
      input  mem_createdump,
      output mem_rdata
   );
endinterface

// File: rtl/mem_copy_dma.sv
// Forward word-by-word memory copy engine: one READ then one WRITE per word,
// with an optional one-cycle memory dump before the completion pulse.
module mem_copy_dma (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           src_addr,
   input  logic [15:0]           dst_addr,
   input  logic [15:0]           len,
   input  logic                  dump_req,
   output logic                  busy,
   output logic                  done,
   mem_copy_dma_if.master        mem
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, DUMP, DONE} state_t;

   state_t      state;
   logic [15:0] src_q;
   logic [15:0] dst_q;
   logic [15:0] len_q;
   logic        dump_q;
   logic [15:0] idx_q;
   logic [15:0] data_q;
   logic [16:0] idx_inc;

   assign idx_inc       = {1'b0, idx_q} + 17'd1;
   assign mem.mem_wdata = data_q;

   // Memory outputs are registered: each transition loads the values the next state drives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         src_q              <= '0;
         dst_q              <= '0;
         len_q              <= '0;
         dump_q             <= 1'b0;
         idx_q              <= '0;
         data_q             <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         mem.mem_enable     <= 1'b0;
         mem.mem_wr         <= 1'b0;
         mem.mem_addr       <= '0;
         mem.mem_createdump <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_q  <= src_addr;
                  dst_q  <= dst_addr;
                  len_q  <= len;
                  dump_q <= dump_req;
                  idx_q  <= '0;
                  if (len != 16'd0) begin
                     state          <= READ;
                     busy           <= 1'b1;
                     mem.mem_enable <= 1'b1;
                     mem.mem_wr     <= 1'b0;
                     mem.mem_addr   <= src_addr;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            READ: begin
               state        <= WRITE;
               data_q       <= mem.mem_rdata;
               mem.mem_wr   <= 1'b1;
               mem.mem_addr <= dst_q + idx_q;
            end
            WRITE: begin
               idx_q      <= idx_inc[15:0];
               data_q     <= '0;
               mem.mem_wr <= 1'b0;
               if (idx_inc < {1'b0, len_q}) begin
                  state        <= READ;
                  mem.mem_addr <= src_q + idx_inc[15:0];
               end else begin
                  mem.mem_enable <= 1'b0;
                  mem.mem_addr   <= '0;
                  if (dump_q) begin
                     state              <= DUMP;
                     mem.mem_createdump <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DUMP: begin
               state              <= DONE;
               mem.mem_createdump <= 1'b0;
               busy               <= 1'b0;
               done               <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state              <= IDLE;
               busy               <= 1'b0;
               done               <= 1'b0;
               mem.mem_enable     <= 1'b0;
               mem.mem_wr         <= 1'b0;
               mem.mem_addr       <= '0;
               mem.mem_createdump <= 1'b0;
               data_q             <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: expected bus events are queued by the stimulus
// and consumed by a monitor that watches the memory bus and completion pulse.
module tb_mem_copy_dma;

   typedef struct {
      int          kind;   // 0 read, 1 write, 2 dump, 3 done
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src_addr = '0;
   logic [15:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        dump_req = 1'b0;
   logic        busy;
   logic        done;

   mem_copy_dma_if bus ();

   mem_copy_dma dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .dump_req (dump_req),
      .busy     (busy),
      .done     (done),
      .mem      (bus.master)
   );

   logic [15:0] mem [0:65535];
   ev_t         exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          start_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.mem_rdata = (bus.mem_enable && !bus.mem_wr) ? mem[bus.mem_addr] : 16'h0000;
   always @(posedge clk) if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

   function automatic void push(int kind, logic [15:0] addr, logic [15:0] data, int c);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   // Monitor: one scoreboard pop per observed bus event, plus quiet-bus checks otherwise.
   always @(negedge clk) begin
      int  k, kind;
      bit  ok;
      ev_t e;
      if (rst && (bus.mem_enable || bus.mem_createdump || done)) begin
         kind = bus.mem_enable ? (bus.mem_wr ? 1 : 0) : (bus.mem_createdump ? 2 : 3);
         k = cyc - start_cyc + 1;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h at cycle %0d, expected none", kind, bus.mem_addr, k);
         end else begin
            e = exp_q.pop_front();
            ok = (kind == e.kind) && (k == e.cyc);
            if (kind <= 1) ok = ok && (bus.mem_addr == e.addr) && busy && !done && !bus.mem_createdump;
            if (kind == 1) ok = ok && (bus.mem_wdata == e.data);
            if (kind == 2) ok = ok && busy && !done;
            if (kind == 3) ok = ok && !busy && !bus.mem_createdump;
            if (!ok) begin
               fails++;
               $display("FAIL bus_event: got kind=%0d addr=%h wdata=%h cyc=%0d busy=%b, expected kind=%0d addr=%h wdata=%h cyc=%0d",
                        kind, bus.mem_addr, bus.mem_wdata, k, busy, e.kind, e.addr, e.data, e.cyc);
            end
         end
      end
      if (!bus.mem_enable) begin
         tests++;
         if (bus.mem_wr || bus.mem_addr != 16'h0 || bus.mem_wdata != 16'h0 ||
             (!bus.mem_createdump && busy)) begin
            fails++;
            $display("FAIL quiet_bus: got wr=%b addr=%h wdata=%h busy=%b, expected 0 0000 0000 0",
                     bus.mem_wr, bus.mem_addr, bus.mem_wdata, busy);
         end
      end
   end

   task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input logic dr);
      @(negedge clk);
      src_addr = s; dst_addr = d; len = n; dump_req = dr; start = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start = 1'b0;
      src_addr = 16'hDEAD; dst_addr = 16'hBEEF; len = 16'h0007; dump_req = ~dr;
   endtask

   task automatic check_drained(input string nm);
      repeat (3) @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drained: got %0d pending events, expected 0", nm, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic wait_done(input int budget, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_timeout: got no done within %0d cycles, expected done", nm, budget);
      end
      check_drained(nm);
   endtask

   task automatic check_word(input string nm, input logic [15:0] a, input logic [15:0] v);
      tests++;
      if (mem[a] !== v) begin
         fails++;
         $display("FAIL %s: mem[%h] got %h, expected %h", nm, a, mem[a], v);
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      tests++;
      if (busy || done || bus.mem_enable || bus.mem_createdump || bus.mem_addr != 16'h0 ||
          bus.mem_wr || bus.mem_wdata != 16'h0) begin
         fails++;
         $display("FAIL %s: got busy=%b done=%b en=%b dump=%b addr=%h wr=%b wdata=%h, expected all 0",
                  nm, busy, done, bus.mem_enable, bus.mem_createdump, bus.mem_addr, bus.mem_wr, bus.mem_wdata);
      end
   endtask

   initial begin
      // Reset held low with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
         len = 16'($urandom); dump_req = 1'($urandom);
         #1;
         check_reset_outputs("reset_hold");
      end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic copy
      mem[16'h0010] = 16'hAAAA; mem[16'h0011] = 16'hBBBB; mem[16'h0012] = 16'hCCCC;
      push(0, 16'h0010, 16'h0, 1); push(1, 16'h0100, 16'hAAAA, 2);
      push(0, 16'h0011, 16'h0, 3); push(1, 16'h0101, 16'hBBBB, 4);
      push(0, 16'h0012, 16'h0, 5); push(1, 16'h0102, 16'hCCCC, 6);
      push(3, 16'h0, 16'h0, 7);
      issue(16'h0010, 16'h0100, 16'd3, 1'b0);
      wait_done(20, "copy");
      check_word("copy_w0", 16'h0100, 16'hAAAA);
      check_word("copy_w1", 16'h0101, 16'hBBBB);
      check_word("copy_w2", 16'h0102, 16'hCCCC);

      // Zero length
      push(3, 16'h0, 16'h0, 1);
      issue(16'h0040, 16'h0050, 16'd0, 1'b0);
      wait_done(10, "zero_len");

      // Address wrap
      mem[16'hFFFF] = 16'h1234; mem[16'h0000] = 16'h5678;
      push(0, 16'hFFFF, 16'h0, 1); push(1, 16'h2000, 16'h1234, 2);
      push(0, 16'h0000, 16'h0, 3); push(1, 16'h2001, 16'h5678, 4);
      push(3, 16'h0, 16'h0, 5);
      issue(16'hFFFF, 16'h2000, 16'd2, 1'b0);
      wait_done(20, "wrap");
      check_word("wrap_w0", 16'h2000, 16'h1234);
      check_word("wrap_w1", 16'h2001, 16'h5678);

      // Start while busy and in DONE is ignored; dump precedes done
      mem[16'h0600] = 16'h0A0A; mem[16'h0601] = 16'h0B0B;
      push(0, 16'h0600, 16'h0, 1); push(1, 16'h0700, 16'h0A0A, 2);
      push(0, 16'h0601, 16'h0, 3); push(1, 16'h0701, 16'h0B0B, 4);
      push(2, 16'h0, 16'h0, 5);    push(3, 16'h0, 16'h0, 6);
      issue(16'h0600, 16'h0700, 16'd2, 1'b1);
      @(negedge clk);
      src_addr = 16'h0800; dst_addr = 16'h0900; len = 16'd5; dump_req = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check_drained("ignored_start");
      check_word("ign_w0", 16'h0700, 16'h0A0A);
      check_word("ign_w1", 16'h0701, 16'h0B0B);
      check_word("ign_other", 16'h0900, 16'h0000);

      // Mid-transfer reset after the first write
      mem[16'h0300] = 16'h0001; mem[16'h0301] = 16'h0002;
      mem[16'h0302] = 16'h0003; mem[16'h0303] = 16'h0004;
      for (int a = 16'h0400; a < 16'h0404; a++) mem[a] = 16'h5555;
      push(0, 16'h0300, 16'h0, 1); push(1, 16'h0400, 16'h0001, 2);
      issue(16'h0300, 16'h0400, 16'd4, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check_reset_outputs("midreset_outputs");
      @(negedge clk);
      rst = 1'b1;
      check_drained("midreset");
      check_word("midreset_w0", 16'h0400, 16'h0001);
      check_word("midreset_w1", 16'h0401, 16'h5555);
      check_word("midreset_w2", 16'h0402, 16'h5555);
      check_word("midreset_w3", 16'h0403, 16'h5555);

      push(0, 16'h0303, 16'h0, 1); push(1, 16'h0500, 16'h0004, 2);
      push(3, 16'h0, 16'h0, 3);
      issue(16'h0303, 16'h0500, 16'd1, 1'b0);
      wait_done(10, "after_reset");
      check_word("after_reset_w0", 16'h0500, 16'h0004);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200000, expected finish");
      $fatal(1, "timeout");
   end

endmodule
